// File: rtl/rv_fetch_queue.sv
// rv_fetch_queue: fetch PC generator with a small prefetch FIFO.
// Issues one IM read per cycle while room remains, queues {instr, PC}.
module rv_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       IM_en,
  output logic [XLEN-1:0]            IM_address,
  input  logic [31:0]                IM_out,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [XLEN-1:0]            out_PC,
  output logic [XLEN-1:0]            out_PC4,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] flight_pc;
  logic            inflight;

  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   cnt;

  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     occ;
  logic            unused_bits;

  // Handshake, occupancy look-ahead and issue decision.
  always_comb begin
    out_valid = !rst && !redirect && (cnt != '0);
    pop       = out_valid && out_ready;
    push      = inflight && !rst && !redirect;
    occ       = {1'b0, cnt}
              + (CW+1)'(inflight)
              - (CW+1)'(pop);
    issue     = !rst && !redirect
              && (occ < (CW+1)'(DEPTH));
  end

  assign IM_en       = issue;
  assign IM_address  = fetch_pc;
  assign out_instr   = instr_q[rptr];
  assign out_PC      = pc_q[rptr];
  assign out_PC4     = pc_q[rptr] + XLEN'(4);
  assign count       = rst ? '0 : cnt;
  assign unused_bits = ^redirect_pc[1:0];

  // Fetch PC, in-flight flag, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
    end else begin
      inflight <= issue;
      if (issue)
        fetch_pc <= fetch_pc + XLEN'(4);
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Remember the PC of the request whose word arrives next cycle.
  always_ff @(posedge clk) begin
    if (issue)
      flight_pc <= fetch_pc;
  end

  // FIFO storage: the returning word is paired with its PC at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wptr] <= IM_out;
      pc_q[wptr]    <= flight_pc;
    end
  end

endmodule

// File: tb/tb_rv_fetch_queue.sv
// tb_rv_fetch_queue: randomized and directed checks of rv_fetch_queue
// against a queue-based reference model.
module tb_rv_fetch_queue;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] WPC   = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, redirect, out_ready;
  logic [31:0]   redirect_pc, im_out, im_addr;
  logic          im_en, out_valid;
  logic [31:0]   out_instr, out_pc, out_pc4;
  logic [CW-1:0] count;

  logic          w_rst, w_redirect, w_out_ready;
  logic [31:0]   w_redirect_pc, w_im_out, w_im_addr;
  logic          w_im_en, w_out_valid;
  logic [31:0]   w_out_instr, w_out_pc, w_out_pc4;
  logic [CW-1:0] w_count;

  rv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .IM_en(im_en), .IM_address(im_addr),
    .IM_out(im_out), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_PC(out_pc), .out_PC4(out_pc4),
    .count(count));

  rv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(WPC)) dut_w (
    .clk(clk), .rst(w_rst), .IM_en(w_im_en), .IM_address(w_im_addr),
    .IM_out(w_im_out), .redirect(w_redirect),
    .redirect_pc(w_redirect_pc),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .out_instr(w_out_instr), .out_PC(w_out_pc), .out_PC4(w_out_pc4),
    .count(w_count));

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Instruction memory: one-cycle read latency, garbage when idle.
  always @(posedge clk) begin
    im_out   <= im_en   ? word(im_addr)   : $urandom;
    w_im_out <= w_im_en ? word(w_im_addr) : $urandom;
  end

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_pc;
  logic [63:0] m_q[$];

  bit          e_valid, e_pop, e_issue;
  logic [31:0] e_instr, e_pc;
  logic [CW-1:0] e_cnt;

  task automatic drive(input bit r, input bit rd,
                       input logic [31:0] rpc, input bit rdy);
    logic [63:0] hd;
    rst = r; redirect = rd; redirect_pc = rpc; out_ready = rdy;
    #1;
    e_valid = !r && !rd && (m_q.size() > 0);
    e_pop   = e_valid && rdy;
    e_issue = !r && !rd &&
              ((m_q.size() + int'(m_pend) - int'(e_pop)) < DEPTH);
    e_cnt   = r ? '0 : CW'(m_q.size());
    hd      = (m_q.size() > 0) ? m_q[0] : 64'h0;
    e_instr = hd[63:32];
    e_pc    = hd[31:0];
  endtask

  task automatic tick;
    if (rst) begin
      m_q.delete(); m_pend = 0; m_pc = 32'h0;
    end else if (redirect) begin
      m_q.delete(); m_pend = 0;
      m_pc = {redirect_pc[31:2], 2'b00};
    end else begin
      if (e_pop) void'(m_q.pop_front());
      if (m_pend) m_q.push_back({word(m_pend_pc), m_pend_pc});
      m_pend = e_issue;
      if (e_issue) begin
        m_pend_pc = m_pc;
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    drive(1, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1'($urandom), $urandom, 1'($urandom));
      n_vec++;
      if (im_en !== 1'b0) begin
        n_err++; $display("FAIL reset_im_en got %b want 0", im_en);
      end
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_valid got %b want 0", out_valid);
      end
      n_vec++;
      if (count !== '0) begin
        n_err++; $display("FAIL reset_count got %0d want 0", count);
      end
      tick();
    end
  endtask

  task automatic test_stream;
    drive(1, 0, 0, 1); tick();
    for (int c = 0; c < 12; c++) begin
      drive(0, 0, 0, 1);
      n_vec++;
      if (im_en !== e_issue || (e_issue && im_addr !== m_pc)) begin
        n_err++;
        $display("FAIL stream_issue c%0d got %b/%h want %b/%h",
                 c, im_en, im_addr, e_issue, m_pc);
      end
      n_vec++;
      if (out_valid !== e_valid) begin
        n_err++;
        $display("FAIL stream_valid c%0d got %b want %b",
                 c, out_valid, e_valid);
      end
      if (e_valid) begin
        n_vec++;
        if (out_pc !== e_pc || out_pc4 !== e_pc + 32'd4 ||
            out_instr !== e_instr) begin
          n_err++;
          $display("FAIL stream_head c%0d got %h/%h/%h want %h/%h/%h",
                   c, out_pc, out_pc4, out_instr,
                   e_pc, e_pc + 32'd4, e_instr);
        end
      end
      if (c == 0) begin
        n_vec++;
        if (im_addr !== 32'h0) begin
          n_err++; $display("FAIL first_addr got %h want 0", im_addr);
        end
      end
      if (c == 2) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 ||
            out_pc4 !== 32'h4) begin
          n_err++;
          $display("FAIL first_out got %b/%h/%h want 1/0/4",
                   out_valid, out_pc, out_pc4);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure;
    drive(1, 0, 0, 0); tick();
    for (int c = 0; c < 10; c++) begin
      drive(0, 0, 0, 0);
      n_vec++;
      if (im_en !== e_issue || count !== e_cnt) begin
        n_err++;
        $display("FAIL bp_fill c%0d got en%b cnt%0d want en%b cnt%0d",
                 c, im_en, count, e_issue, e_cnt);
      end
      if (c == 9) begin
        n_vec++;
        if (count !== CW'(DEPTH) || im_en !== 1'b0) begin
          n_err++;
          $display("FAIL bp_full got cnt%0d en%b want cnt4 en0",
                   count, im_en);
        end
      end
      tick();
    end
    for (int c = 0; c < 8; c++) begin
      drive(0, 0, 0, 1);
      n_vec++;
      if (out_valid !== e_valid || (e_valid && out_pc !== e_pc)) begin
        n_err++;
        $display("FAIL bp_drain c%0d got %b/%h want %b/%h",
                 c, out_valid, out_pc, e_valid, e_pc);
      end
      if (c < 4) begin
        n_vec++;
        if (out_pc !== 32'(c * 4)) begin
          n_err++;
          $display("FAIL bp_order c%0d got %h want %h",
                   c, out_pc, 32'(c * 4));
        end
      end
      if (c == 0) begin
        n_vec++;
        if (im_en !== 1'b1 || im_addr !== 32'h10) begin
          n_err++;
          $display("FAIL bp_resume got %b/%h want 1/10", im_en, im_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_redirect;
    drive(1, 0, 0, 1); tick();
    for (int c = 0; c < 14; c++) begin
      if (c == 4)      drive(0, 1, 32'h100, 1);
      else if (c == 9) drive(0, 1, 32'h203, 1);
      else             drive(0, 0, 0, 1);
      n_vec++;
      if (out_valid !== e_valid || im_en !== e_issue ||
          count !== e_cnt) begin
        n_err++;
        $display("FAIL redir_model c%0d got v%b e%b n%0d want v%b e%b n%0d",
                 c, out_valid, im_en, count, e_valid, e_issue, e_cnt);
      end
      if (c == 4) begin
        n_vec++;
        if (out_valid !== 1'b0 || im_en !== 1'b0) begin
          n_err++;
          $display("FAIL redir_cycle got v%b e%b want v0 e0",
                   out_valid, im_en);
        end
      end
      if (c == 5) begin
        n_vec++;
        if (count !== '0 || im_en !== 1'b1 || im_addr !== 32'h100) begin
          n_err++;
          $display("FAIL redir_next got n%0d e%b %h want n0 e1 100",
                   count, im_en, im_addr);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
          n_err++;
          $display("FAIL redir_head got %b/%h want 1/100",
                   out_valid, out_pc);
        end
      end
      if (c == 10) begin
        n_vec++;
        if (im_en !== 1'b1 || im_addr !== 32'h200) begin
          n_err++;
          $display("FAIL redir_align got %b/%h want 1/200",
                   im_en, im_addr);
        end
      end
      if (c == 12) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 32'h200 ||
            out_instr !== word(32'h200)) begin
          n_err++;
          $display("FAIL redir_align_head got %b/%h/%h want 1/200/%h",
                   out_valid, out_pc, out_instr, word(32'h200));
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid;
    drive(1, 0, 0, 0); tick();
    for (int c = 0; c < 10; c++) begin
      drive(c == 4, 0, 0, c > 4);
      if (c == 4) begin
        n_vec++;
        if (out_valid !== 1'b0 || im_en !== 1'b0 || count !== '0) begin
          n_err++;
          $display("FAIL rstmid_during got v%b e%b n%0d want 0 0 0",
                   out_valid, im_en, count);
        end
      end
      if (c == 5) begin
        n_vec++;
        if (out_valid !== 1'b0 || count !== '0 ||
            im_en !== 1'b1 || im_addr !== 32'h0) begin
          n_err++;
          $display("FAIL rstmid_after got v%b n%0d e%b %h want 0 0 1 0",
                   out_valid, count, im_en, im_addr);
        end
      end
      if (c == 7) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0 ||
            out_instr !== word(32'h0)) begin
          n_err++;
          $display("FAIL rstmid_head got %b/%h/%h want 1/0/%h",
                   out_valid, out_pc, out_instr, word(32'h0));
        end
      end
      n_vec++;
      if (count !== e_cnt || out_valid !== e_valid) begin
        n_err++;
        $display("FAIL rstmid_model c%0d got n%0d v%b want n%0d v%b",
                 c, count, out_valid, e_cnt, e_valid);
      end
      tick();
    end
  endtask

  task automatic test_random;
    drive(1, 0, 0, 0); tick();
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 15) == 0,
            {20'h0, 12'($urandom)},
            1'($urandom_range(0, 3) != 0));
      n_vec++;
      if (im_en !== e_issue || (e_issue && im_addr !== m_pc) ||
          out_valid !== e_valid || count !== e_cnt) begin
        n_err++;
        $display("FAIL rand_ctl c%0d got e%b %h v%b n%0d want e%b %h v%b n%0d",
                 c, im_en, im_addr, out_valid, count,
                 e_issue, m_pc, e_valid, e_cnt);
      end
      if (e_valid) begin
        n_vec++;
        if (out_pc !== e_pc || out_instr !== e_instr ||
            out_pc4 !== e_pc + 32'd4) begin
          n_err++;
          $display("FAIL rand_head c%0d got %h/%h/%h want %h/%h/%h",
                   c, out_pc, out_instr, out_pc4,
                   e_pc, e_instr, e_pc + 32'd4);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap;
    drive(1, 0, 0, 0);
    w_rst = 1'b1;
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(1, 0, 0, 0);
      w_rst = 1'b0;
      #1;
      if (c == 0) begin
        n_vec++;
        if (w_im_en !== 1'b1 || w_im_addr !== WPC) begin
          n_err++;
          $display("FAIL wrap_first got %b/%h want 1/%h",
                   w_im_en, w_im_addr, WPC);
        end
      end
      if (c == 1) begin
        n_vec++;
        if (w_im_en !== 1'b1 || w_im_addr !== 32'h0) begin
          n_err++;
          $display("FAIL wrap_next got %b/%h want 1/0",
                   w_im_en, w_im_addr);
        end
      end
      if (c == 2) begin
        n_vec++;
        if (w_out_valid !== 1'b1 || w_out_pc !== WPC ||
            w_out_pc4 !== 32'h0 || w_out_instr !== word(WPC)) begin
          n_err++;
          $display("FAIL wrap_head got %b/%h/%h/%h want 1/%h/0/%h",
                   w_out_valid, w_out_pc, w_out_pc4, w_out_instr,
                   WPC, word(WPC));
        end
      end
      if (c == 3) begin
        n_vec++;
        if (w_out_valid !== 1'b1 || w_out_pc !== 32'h0 ||
            w_out_pc4 !== 32'h4) begin
          n_err++;
          $display("FAIL wrap_second got %b/%h/%h want 1/0/4",
                   w_out_valid, w_out_pc, w_out_pc4);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    w_rst = 1'b1; w_redirect = 1'b0; w_redirect_pc = '0;
    w_out_ready = 1'b1;
    m_pc = '0; m_pend = 0; m_pend_pc = '0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
